score_frame_loader: RTL and testbench

- Producer side of the class-score interface consumed by the max selector.
- Accepts class scores as a serial valid/ready stream, one per beat, in class order 0..NUM_CLASSES-1.
- Assembles the scores into a parallel frame and presents it stable with frame_valid until the consumer acknowledges.
- Detects framing errors (in_last early or missing) and discards the bad frame.

---
 rtl/score_frame_loader.sv | 198 +++++++++++++++++++
 tb/tb_score_frame_loader.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/score_frame_loader.sv
// ============================================================================
// Module   : score_frame_loader
// Purpose  : Producer side of the class-score interface feeding the max
//            selector. Collects NUM_CLASSES serial score beats (valid/ready,
//            class order 0..NUM_CLASSES-1) into a parallel frame and holds
//            it stable with frame_valid until frame_ack. Frames that end
//            early or run past NUM_CLASSES beats without in_last are dropped
//            and flagged on the sticky frame_err output.
// Ports    : clk         rising-edge clock
//            rst         asynchronous reset, active-low
//            in_valid    stream beat valid
//            in_ready    loader can accept a beat (registered)
//            in_score    unsigned score for the current class
//            in_last     final beat of a frame
//            scores_flat class k at [k*SCORE_W +: SCORE_W]
//            frame_valid complete frame held on scores_flat
//            frame_ack   consumer has sampled the frame
//            frame_err   sticky framing-error flag
//            err_clr     clears frame_err (a simultaneous new error wins)
// Options  : SCORE_CLEAR_ON_ACK_EN - when defined, every score slot is
//            zeroed on HOLD->COLLECT and on any framing error.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module score_frame_loader #(
   parameter int NUM_CLASSES = 10,
   parameter int SCORE_W     = 26,
   parameter int CNT_W       = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [SCORE_W-1:0]             in_score,
   input  logic                           in_last,
   output logic [NUM_CLASSES*SCORE_W-1:0] scores_flat,
   output logic                           frame_valid,
   input  logic                           frame_ack,
   output logic                           frame_err,
   input  logic                           err_clr
);

   typedef enum logic [0:0] {
      ST_COLLECT = 1'b0,
      ST_HOLD    = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] c_last_idx = CNT_W'(NUM_CLASSES - 1);

   state_t               r_state;
   state_t               w_state_nxt;
   logic [CNT_W-1:0]     r_count;
   logic [CNT_W-1:0]     w_count_nxt;
   logic                 r_in_ready;
   logic                 r_frame_valid;
   logic                 r_frame_err;
   logic                 w_frame_err_nxt;
   logic                 w_accept;
   logic                 w_write;
   logic                 w_err_set;
   logic [SCORE_W-1:0]   r_slot [NUM_CLASSES];
`ifdef SCORE_CLEAR_ON_ACK_EN
   logic                 w_clear_all;
`endif

   // in_ready is only ever high in COLLECT, so this also qualifies the state.
   assign w_accept = in_valid & r_in_ready;

   // ------------------------------------------------------------------------
   // Next-state / control decode
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_count_nxt = r_count;
      w_write     = 1'b0;
      w_err_set   = 1'b0;
`ifdef SCORE_CLEAR_ON_ACK_EN
      w_clear_all = 1'b0;
`endif

      case (r_state)
         ST_COLLECT: begin
            if (w_accept) begin
               w_write = 1'b1;
               if (in_last) begin
                  w_count_nxt = '0;
                  if (r_count == c_last_idx) begin
                     w_state_nxt = ST_HOLD;
                  end else begin
                     // Short frame: drop it and restart at class 0.
                     w_err_set = 1'b1;
                  end
               end else if (r_count == c_last_idx) begin
                  // Long frame: the next beat is taken as class 0.
                  w_count_nxt = '0;
                  w_err_set   = 1'b1;
               end else begin
                  w_count_nxt = r_count + 1'b1;
               end
            end
         end
         ST_HOLD: begin
            if (frame_ack) begin
               w_state_nxt = ST_COLLECT;
`ifdef SCORE_CLEAR_ON_ACK_EN
               w_clear_all = 1'b1;
`endif
            end
         end
         default: begin
            w_state_nxt = ST_COLLECT;
            w_count_nxt = '0;
         end
      endcase

`ifdef SCORE_CLEAR_ON_ACK_EN
      if (w_err_set) begin
         w_clear_all = 1'b1;
      end
`endif

      // Set has priority over clear so a fresh error is never lost.
      if (w_err_set) begin
         w_frame_err_nxt = 1'b1;
      end else if (err_clr) begin
         w_frame_err_nxt = 1'b0;
      end else begin
         w_frame_err_nxt = r_frame_err;
      end
   end

   // ------------------------------------------------------------------------
   // State and control registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state       <= ST_COLLECT;
         r_count       <= '0;
         r_in_ready    <= 1'b1;
         r_frame_valid <= 1'b0;
         r_frame_err   <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_count       <= w_count_nxt;
         r_in_ready    <= (w_state_nxt == ST_COLLECT);
         r_frame_valid <= (w_state_nxt == ST_HOLD);
         r_frame_err   <= w_frame_err_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // Score slots: written only by accepted beats
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < NUM_CLASSES; k++) begin
            r_slot[k] <= '0;
         end
      end else begin
`ifdef SCORE_CLEAR_ON_ACK_EN
         if (w_clear_all) begin
            for (int k = 0; k < NUM_CLASSES; k++) begin
               r_slot[k] <= '0;
            end
         end else begin
            for (int k = 0; k < NUM_CLASSES; k++) begin
               if (w_write && (r_count == CNT_W'(k))) begin
                  r_slot[k] <= in_score;
               end
            end
         end
`else
         for (int k = 0; k < NUM_CLASSES; k++) begin
            if (w_write && (r_count == CNT_W'(k))) begin
               r_slot[k] <= in_score;
            end
         end
`endif
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < NUM_CLASSES; gi++) begin : g_flat
         assign scores_flat[gi*SCORE_W +: SCORE_W] = r_slot[gi];
      end
   endgenerate

   assign in_ready    = r_in_ready;
   assign frame_valid = r_frame_valid;
   assign frame_err   = r_frame_err;

endmodule

`default_nettype wire

// File: tb/tb_score_frame_loader.sv
`default_nettype none

module tb_score_frame_loader;

   localparam int N  = 10;
   localparam int W  = 26;
   localparam int FW = N * W;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_score;
   logic          in_last;
   logic [FW-1:0] scores_flat;
   logic          frame_valid;
   logic          frame_ack;
   logic          frame_err;
   logic          err_clr;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: the scores of the current frame, the slot contents
   // seen by the consumer, the sticky error and whether a frame is held.
   logic [W-1:0] m_slot [N];
   logic [W-1:0] m_cur [$];
   bit           m_err;
   bit           m_hold;

   score_frame_loader #(.NUM_CLASSES(N), .SCORE_W(W), .CNT_W(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_score    (in_score),
      .in_last     (in_last),
      .scores_flat (scores_flat),
      .frame_valid (frame_valid),
      .frame_ack   (frame_ack),
      .frame_err   (frame_err),
      .err_clr     (err_clr)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: observed no finish, expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [FW-1:0] exp_flat();
      logic [FW-1:0] r;
      for (int k = 0; k < N; k++) r[k*W +: W] = m_slot[k];
      return r;
   endfunction

   task automatic model_zero();
      for (int k = 0; k < N; k++) m_slot[k] = '0;
   endtask

   task automatic model_reset();
      model_zero();
      m_cur.delete();
      m_err  = 1'b0;
      m_hold = 1'b0;
   endtask

   // One accepted beat, in frame-level terms.
   task automatic model_beat(input logic [W-1:0] s, input bit l, input bit clr);
      bit bad;
      bad = 1'b0;
      m_slot[m_cur.size()] = s;
      m_cur.push_back(s);
      if (l) begin
         if (m_cur.size() == N) m_hold = 1'b1;
         else bad = 1'b1;
         m_cur.delete();
      end else if (m_cur.size() == N) begin
         bad = 1'b1;
         m_cur.delete();
      end
`ifdef SCORE_CLEAR_ON_ACK_EN
      if (bad) model_zero();
`endif
      if (bad) m_err = 1'b1;
      else if (clr) m_err = 1'b0;
   endtask

   // Called just after a falling edge; returns just after a falling edge.
   task automatic beat(input logic [W-1:0] s, input bit l, input bit clr);
      bit ok;
      ok       = 1'b0;
      in_valid = 1'b1;
      in_score = s;
      in_last  = l;
      err_clr  = clr;
      for (int t = 0; t < 200 && !ok; t++) begin
         if (in_ready === 1'b1) ok = 1'b1;
         @(negedge clk);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      err_clr  = 1'b0;
      if (ok) begin
         model_beat(s, l, clr);
      end else begin
         n_cmp++;
         n_bad++;
         $error("FAIL beat_timeout: observed in_ready low for 200 cycles, expected accept");
      end
   endtask

   task automatic ack();
      frame_ack = 1'b1;
      @(negedge clk);
      frame_ack = 1'b0;
      if (m_hold) begin
         m_hold = 1'b0;
`ifdef SCORE_CLEAR_ON_ACK_EN
         model_zero();
`endif
      end
   endtask

   task automatic clear_err();
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      m_err   = 1'b0;
   endtask

   task automatic check_all(input string tag);
      chk({tag, "_valid"}, FW'(frame_valid), FW'(m_hold));
      chk({tag, "_ready"}, FW'(in_ready), FW'(!m_hold));
      chk({tag, "_err"},   FW'(frame_err), FW'(m_err));
      chk({tag, "_flat"},  scores_flat, exp_flat());
   endtask

   task automatic rand_frame(input logic [W-1:0] first);
      for (int k = 0; k < N; k++)
         beat((k == 0) ? first : W'($urandom), k == N - 1, 1'b0);
   endtask

   initial begin
      logic [FW-1:0] held;
      logic [W-1:0]  v11;
      int            kind;
      int            len;

      rst       = 1'b0;
      in_valid  = 1'b0;
      in_score  = '0;
      in_last   = 1'b0;
      frame_ack = 1'b0;
      err_clr   = 1'b0;
      model_reset();

      // Reset values
      #12;
      check_all("reset");
      @(negedge clk);
      rst = 1'b1;

      // Normal frame 100..1000
      for (int k = 0; k < N; k++) beat(W'(100 * (k + 1)), k == N - 1, 1'b0);
      check_all("normal");
      chk("normal_slot0", FW'(scores_flat[0 +: W]), FW'(100));
      chk("normal_slot9", FW'(scores_flat[9*W +: W]), FW'(1000));
      ack();
      check_all("normal_ack");

      // Backpressure: a beat waiting in HOLD must not be consumed
      rand_frame(W'($urandom));
      held     = scores_flat;
      in_valid = 1'b1;
      in_score = 26'h0ABCDEF;
      in_last  = 1'b0;
      for (int t = 0; t < 20; t++) begin
         @(negedge clk);
         chk("bp_ready", FW'(in_ready), FW'(0));
      end
      chk("bp_flat", scores_flat, held);
      chk("bp_valid", FW'(frame_valid), FW'(1));
      ack();
      chk("bp_ready_after_ack", FW'(in_ready), FW'(1));
      @(negedge clk);
      in_valid = 1'b0;
      model_beat(26'h0ABCDEF, 1'b0, 1'b0);
      chk("bp_slot0", FW'(scores_flat[0 +: W]), FW'(26'h0ABCDEF));
      for (int k = 1; k < N; k++) beat(W'($urandom), k == N - 1, 1'b0);
      check_all("bp_frame");
      ack();

      // Short frame: in_last on beat 4
      for (int k = 0; k < 4; k++) beat(W'($urandom), k == 3, 1'b0);
      check_all("short");
      chk("short_err", FW'(frame_err), FW'(1));
      rand_frame(W'($urandom));
      check_all("short_next");
      ack();
      clear_err();
      check_all("short_clr");

      // Long frame: 10 beats without in_last, then a correct frame
      for (int k = 0; k < N; k++) beat(W'($urandom), 1'b0, 1'b0);
      check_all("long");
      v11 = W'($urandom);
      rand_frame(v11);
      check_all("long_next");
      chk("long_slot0", FW'(scores_flat[0 +: W]), FW'(v11));
      ack();
      clear_err();

      // Error and err_clr in the same cycle: the error wins
      beat(W'($urandom), 1'b0, 1'b0);
      beat(W'($urandom), 1'b1, 1'b1);
      check_all("setwins");
      clear_err();

      // Asynchronous reset after beat 5
      for (int k = 0; k < 5; k++) beat(W'($urandom), 1'b0, 1'b0);
      #3 rst = 1'b0;
      #1;
      model_reset();
      check_all("async_rst");
      @(negedge clk);
      rst = 1'b1;
      rand_frame(W'($urandom));
      check_all("after_rst");
      ack();

      // Gapped stream of max-value scores
      for (int k = 0; k < N; k++) begin
         beat(26'h3FFFFFF, k == N - 1, 1'b0);
         if (k < N - 1) chk("gap_no_valid", FW'(frame_valid), FW'(0));
         @(negedge clk);
      end
      check_all("gapped");
      ack();
      check_all("gapped_ack");

      // Randomised frames: normal, short, long, with gaps and ack delays
      for (int it = 0; it < 40; it++) begin
         kind = $urandom_range(0, 9);
         if (kind < 7) len = N;
         else if (kind < 9) len = $urandom_range(1, N - 1);
         else len = N;
         for (int k = 0; k < len; k++) begin
            beat(W'($urandom), (kind != 9) && (k == len - 1),
                 ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
         end
         check_all("rnd");
         if (m_hold) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            check_all("rnd_hold");
            ack();
            check_all("rnd_ack");
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
